// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer (master) and instruction memory (slave).
interface fetch_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: owns the PC, fetches over a req/ack bus and strobes one execute cycle.
// Optional build macro SEQ_SINGLE_STEP_EN adds debug single-step inputs.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic                i_halt_req,
  fetch_sequencer_if.master   imem,
  output logic [15:0]         o_inst,
  output logic                o_exec_en,
  input  logic                i_jmp_if,
  input  logic [15:0]         i_a,
  output logic [15:0]         o_pc,
  output logic                o_halted,
  output logic                o_fault,
  output logic [31:0]         o_instret
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic                i_dbg_step_mode,
  input  logic                i_dbg_step
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] r_inst;
  logic [31:0] r_instret;
  logic [7:0]  r_tcnt;
  logic        r_halt_pend;
  logic        r_imem_req;
  logic        r_exec_en;
  logic        r_halted;
  logic        r_fault;

  logic        w_go;
  logic        w_step_stop;
  logic        w_halt_now;
  logic        w_self_loop;
  logic        w_timeout;
  logic        w_handshake;
  logic        w_req_nxt;
  logic        w_exec_nxt;
  logic        w_halted_nxt;
  logic        w_fault_nxt;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_go        = i_run | i_dbg_step;
  assign w_step_stop = i_dbg_step_mode;
`else
  assign w_go        = i_run;
  assign w_step_stop = 1'b0;
`endif

  assign w_halt_now  = r_halt_pend | i_halt_req;
  assign w_self_loop = i_jmp_if && (i_a == r_pc);
  assign w_timeout   = (r_tcnt == (FETCH_TIMEOUT - 8'd1));
  assign w_handshake = r_imem_req && imem.imem_ack;

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_pc;
  assign o_inst         = r_inst;
  assign o_exec_en      = r_exec_en;
  assign o_pc           = r_pc;
  assign o_halted       = r_halted;
  assign o_fault        = r_fault;
  assign o_instret      = r_instret;

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_imem_req <= 1'b0;
      r_exec_en  <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_imem_req <= w_req_nxt;
      r_exec_en  <= w_exec_nxt;
      r_halted   <= w_halted_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  // Next-state decode; an ack in the timeout cycle still completes the fetch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) w_state_nxt = S_FETCH;
        else      w_state_nxt = S_IDLE;
      end
      S_FETCH: begin
        if (imem.imem_ack) w_state_nxt = S_EXEC;
        else if (w_timeout) w_state_nxt = S_FAULT;
        else w_state_nxt = S_FETCH;
      end
      S_EXEC: begin
        if (w_halt_now || w_self_loop || w_step_stop) w_state_nxt = S_HALT;
        else w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (w_go && !i_halt_req) w_state_nxt = S_FETCH;
        else w_state_nxt = S_HALT;
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so the strobes are registered with it.
  always_comb begin
    w_req_nxt    = 1'b0;
    w_exec_nxt   = 1'b0;
    w_halted_nxt = 1'b0;
    w_fault_nxt  = 1'b0;
    case (w_state_nxt)
      S_FETCH: w_req_nxt    = 1'b1;
      S_EXEC:  w_exec_nxt   = 1'b1;
      S_HALT:  w_halted_nxt = 1'b1;
      S_FAULT: w_fault_nxt  = 1'b1;
      default: w_req_nxt    = 1'b0;
    endcase
  end

  // Datapath: instruction latch, fetch timer, PC/retire update and pending halt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_inst      <= 16'h0000;
      r_instret   <= 32'd0;
      r_tcnt      <= 8'd0;
      r_halt_pend <= 1'b0;
    end else begin
      if (w_handshake) r_inst <= imem.imem_data;
      else             r_inst <= r_inst;

      if ((r_state == S_FETCH) && !imem.imem_ack) r_tcnt <= r_tcnt + 8'd1;
      else                                       r_tcnt <= 8'd0;

      if (r_state == S_EXEC) begin
        r_pc      <= i_jmp_if ? i_a : (r_pc + 16'd1);
        r_instret <= r_instret + 32'd1;
      end else begin
        r_pc      <= r_pc;
        r_instret <= r_instret;
      end

      if (w_state_nxt == S_HALT) r_halt_pend <= 1'b0;
      else if (((r_state == S_FETCH) || (r_state == S_EXEC)) && i_halt_req) r_halt_pend <= 1'b1;
      else r_halt_pend <= r_halt_pend;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed runs, expected retirements queued and checked on exec_en.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        halt_req;
  logic        jmp_if;
  logic [15:0] a;
  logic        dbg_step_mode;
  logic        dbg_step;
  logic [15:0] inst;
  logic        exec_en;
  logic [15:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] instret;

  fetch_sequencer_if bus();

  fetch_sequencer #(
    .RESET_PC      (16'h0000),
    .FETCH_TIMEOUT (8'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (run),
    .i_halt_req (halt_req),
    .imem       (bus),
    .o_inst     (inst),
    .o_exec_en  (exec_en),
    .i_jmp_if   (jmp_if),
    .i_a        (a),
    .o_pc       (pc),
    .o_halted   (halted),
    .o_fault    (fault),
    .o_instret  (instret)
`ifdef SEQ_SINGLE_STEP_EN
    ,
    .i_dbg_step_mode (dbg_step_mode),
    .i_dbg_step      (dbg_step)
`endif
  );

  typedef struct {
    logic [15:0] pc;
    logic [31:0] instret;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_exec = 0;
  int          ack_delay = 0;
  int          wcnt = 0;
  logic        never_ack = 1'b0;
  logic [15:0] rule_pc[3];
  logic [15:0] rule_tgt[3];
  logic        rule_en[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] p, input logic [31:0] n, input int g);
    exp_t e;
    e.pc = p;
    e.instret = n;
    e.gap = g;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic clear_rules();
    for (int i = 0; i < 3; i++) begin
      rule_en[i]  = 1'b0;
      rule_pc[i]  = 16'h0000;
      rule_tgt[i] = 16'h0000;
    end
  endtask

  task automatic set_rule(input int idx, input logic [15:0] p, input logic [15:0] t);
    rule_en[idx]  = 1'b1;
    rule_pc[idx]  = p;
    rule_tgt[idx] = t;
  endtask

  task automatic wait_halted(input int budget, input string name);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, halted}, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},      {16'd0, pc},       32'h0000_0000);
    check({tag, "_inst"},    {16'd0, inst},     32'h0000_0000);
    check({tag, "_instret"}, instret,           32'd0);
    check({tag, "_req"},     {31'd0, bus.imem_req}, 32'd0);
    check({tag, "_exec"},    {31'd0, exec_en},  32'd0);
    check({tag, "_halted"},  {31'd0, halted},   32'd0);
    check({tag, "_fault"},   {31'd0, fault},    32'd0);
  endtask

  // Instruction memory (data = address) and control-unit jump model.
  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    jmp_if = 1'b0;
    a      = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.imem_req && !never_ack) begin
        if (wcnt >= ack_delay) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = bus.imem_addr;
          wcnt = 0;
        end else begin
          bus.imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wcnt = 0;
      end
      jmp_if = 1'b0;
      a      = 16'h0000;
      if (exec_en) begin
        for (int i = 0; i < 3; i++) begin
          if (rule_en[i] && pc == rule_pc[i]) begin
            jmp_if = 1'b1;
            a      = rule_tgt[i];
          end
        end
      end
    end
  end

  // Scoreboard monitor: every exec_en must match the oldest queued retirement.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exec_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_exec actual pc=%h required=no exec", pc);
        end else begin
          e = sb.pop_front();
          check("exec_pc",      {16'd0, pc},   {16'd0, e.pc});
          check("exec_inst",    {16'd0, inst}, {16'd0, e.pc});
          check("exec_instret", instret,       e.instret);
          if (e.gap != 0) check("exec_gap", 32'(cyc - last_exec), 32'(e.gap));
        end
        last_exec = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    halt_req = 1'b0;
    dbg_step_mode = 1'b0;
    dbg_step = 1'b0;
    clear_rules();
    tick();
    tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // Back-to-back fetch with immediate ack, ending on a self-loop at 0x0007.
    set_rule(0, 16'h0007, 16'h0007);
    for (int i = 0; i < 8; i++) push_exp(16'(i), 32'(i), (i == 0) ? 0 : 2);
    pulse_run();
    wait_halted(40, "selfloop_halted");
    check("selfloop_pc",      {16'd0, pc}, 32'h0000_0007);
    check("selfloop_instret", instret,     32'd8);
    tick(); tick(); tick();
    check("selfloop_no_req",  {31'd0, bus.imem_req}, 32'd0);

    // Restart from HALT with a 3-cycle ack delay; request must hold 4 cycles.
    clear_rules();
    ack_delay = 3;
    push_exp(16'h0007, 32'd8, 0);
    pulse_run();
    for (int i = 0; i < 4; i++) begin
      check("slow_req",  {31'd0, bus.imem_req}, 32'd1);
      check("slow_addr", {16'd0, bus.imem_addr}, 32'h0000_0007);
      tick();
    end
    tick();
    push_exp(16'h0008, 32'd9, 0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_halted(20, "haltreq_halted");
    check("haltreq_pc",      {16'd0, pc}, 32'h0000_0009);
    check("haltreq_instret", instret,     32'd10);

    // run together with halt_req keeps the sequencer halted.
    run = 1'b1;
    halt_req = 1'b1;
    tick();
    run = 1'b0;
    halt_req = 1'b0;
    tick(); tick();
    check("runhalt_halted", {31'd0, halted},       32'd1);
    check("runhalt_no_req", {31'd0, bus.imem_req}, 32'd0);

    // Jump 0x0010 -> 0x0040, then self-loop there.
    ack_delay = 0;
    set_rule(0, 16'h0010, 16'h0040);
    set_rule(1, 16'h0040, 16'h0040);
    for (int i = 0; i < 8; i++) push_exp(16'(9 + i), 32'(10 + i), (i == 0) ? 0 : 2);
    push_exp(16'h0040, 32'd18, 2);
    pulse_run();
    wait_halted(60, "jump_halted");
    check("jump_pc",      {16'd0, pc}, 32'h0000_0040);
    check("jump_instret", instret,     32'd19);

    // PC wrap 0xFFFF -> 0x0000, then on to 0x0021 and self-loop.
    clear_rules();
    set_rule(0, 16'h0040, 16'hFFFF);
    set_rule(1, 16'h0000, 16'h0021);
    set_rule(2, 16'h0021, 16'h0021);
    push_exp(16'h0040, 32'd19, 0);
    push_exp(16'hFFFF, 32'd20, 2);
    push_exp(16'h0000, 32'd21, 2);
    push_exp(16'h0021, 32'd22, 2);
    pulse_run();
    wait_halted(40, "wrap_halted");
    check("wrap_pc",      {16'd0, pc}, 32'h0000_0021);
    check("wrap_instret", instret,     32'd23);

    // Fetch timeout: no ack ever, fault after 4 FETCH cycles.
    clear_rules();
    never_ack = 1'b1;
    pulse_run();
    for (int i = 0; i < 4; i++) begin
      check("to_req",   {31'd0, bus.imem_req}, 32'd1);
      check("to_fault", {31'd0, fault},        32'd0);
      tick();
    end
    check("to_fault_set", {31'd0, fault},        32'd1);
    check("to_req_drop",  {31'd0, bus.imem_req}, 32'd0);
    check("to_not_halt",  {31'd0, halted},       32'd0);
    pulse_run();
    tick();
    check("to_run_ignored_fault", {31'd0, fault},        32'd1);
    check("to_run_ignored_req",   {31'd0, bus.imem_req}, 32'd0);
    never_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    check_reset("rst2");
    rst_n = 1'b1;
    tick();
    check("idle_no_req", {31'd0, bus.imem_req}, 32'd0);

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: each dbg_step retires exactly one instruction.
    dbg_step_mode = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(16'(i), 32'(i), 0);
    for (int i = 0; i < 3; i++) begin
      dbg_step = 1'b1;
      tick();
      dbg_step = 1'b0;
      wait_halted(20, "step_halted");
    end
    check("step_instret", instret,     32'd3);
    check("step_pc",      {16'd0, pc}, 32'h0000_0003);
    dbg_step_mode = 1'b0;
`endif

    tick(); tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
